// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result packer: default operand width, byte count, FSM states.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NBYTES    = 2 * WIDTH_DEF / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } pkt_state_e;

  // Bytes needed to carry one 2*w-bit result; w is expected to be a multiple of 4.
  function automatic int nbytes_of(input int w);
    return 2 * w / 8;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Two-entry result FIFO; a pop and a push on the same edge both succeed even when full.
module alu_res_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is read out before it is overwritten.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/alu_result_packer.sv
// Serialises signed ALU results into LSB-first bytes through a 2-deep FIFO plus a shift register.
// Optional macro ALU_PKT_STATUS_EN appends a status byte {6'b0, overrun_at_capture, carry} to each frame.
module alu_result_packer
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2*WIDTH-1:0] Res_In,
  input  logic               Carry_In,
  input  logic               Res_Valid,
  output logic [7:0]         Byte_Out,
  output logic               Byte_Valid,
  input  logic               Byte_Ready,
  output logic               Busy,
  output logic               Overrun
);

  localparam int NB = nbytes_of(WIDTH);
`ifdef ALU_PKT_STATUS_EN
  localparam int FRAME_BYTES = NB + 1;
  localparam int ENTRY_W     = 2 * WIDTH + 2;
`else
  localparam int FRAME_BYTES = NB;
  localparam int ENTRY_W     = 2 * WIDTH;
`endif
  localparam int FRAME_W = 8 * FRAME_BYTES;
  localparam int CNT_W   = $clog2(FRAME_BYTES + 1);

  pkt_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] frame_sr;
  logic               byte_vld;

  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               xfer;
  logic               last;
  logic               drop;

`ifdef ALU_PKT_STATUS_EN
  assign entry_in = {Overrun, Carry_In, Res_In};

  function automatic logic [FRAME_W-1:0] to_frame(input logic [ENTRY_W-1:0] e);
    return {6'b0, e[ENTRY_W-1 -: 2], e[2*WIDTH-1:0]};
  endfunction
`else
  logic carry_unused;
  assign carry_unused = Carry_In;
  assign entry_in     = Res_In;

  function automatic logic [FRAME_W-1:0] to_frame(input logic [ENTRY_W-1:0] e);
    return e;
  endfunction
`endif

  assign xfer = byte_vld && Byte_Ready;
  assign last = (cnt == CNT_W'(FRAME_BYTES - 1));
  assign pop  = !fifo_empty && ((state == IDLE) || (xfer && last));
  assign push = Res_Valid && !RST;
  assign drop = Res_Valid && fifo_full && !pop;

  alu_res_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (entry_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serialiser stage: frame_sr holds the frame in flight, its low byte drives Byte_Out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      frame_sr <= '0;
      byte_vld <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      if (drop) Overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            frame_sr <= to_frame(fifo_dout);
            cnt      <= '0;
            byte_vld <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last) begin
              cnt <= '0;
              if (!fifo_empty) begin
                frame_sr <= to_frame(fifo_dout);
              end else begin
                byte_vld <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              cnt      <= cnt + CNT_W'(1);
              frame_sr <= frame_sr >> 8;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Byte_Out   = frame_sr[7:0];
  assign Byte_Valid = byte_vld;
  assign Busy       = (state == SEND) || !fifo_empty;

endmodule

// File: tb/tb_alu_result_packer.sv
// Directed self-checking bench for alu_result_packer at WIDTH=16.
module tb_alu_result_packer;

`ifdef ALU_PKT_STATUS_EN
  localparam int FB = 5;
`else
  localparam int FB = 4;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] Res_In = '0;
  logic        Carry_In = 1'b0;
  logic        Res_Valid = 1'b0;
  logic [7:0]  Byte_Out;
  logic        Byte_Valid;
  logic        Byte_Ready = 1'b0;
  logic        Busy;
  logic        Overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];

  alu_result_packer #(.WIDTH(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Res_In     (Res_In),
    .Carry_In   (Carry_In),
    .Res_Valid  (Res_Valid),
    .Byte_Out   (Byte_Out),
    .Byte_Valid (Byte_Valid),
    .Byte_Ready (Byte_Ready),
    .Busy       (Busy),
    .Overrun    (Overrun)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] frame_byte(input logic [31:0] res, input logic c,
                                            input logic o, input int idx);
    logic [31:0] r;
    r = res;
    if (idx < 4) return r[8*idx +: 8];
    return {6'b0, o, c};
  endfunction

  task automatic add_frame(input logic [31:0] res, input logic c, input logic o);
    for (int i = 0; i < FB; i++) expq.push_back(frame_byte(res, c, o, i));
  endtask

  task automatic drain_check(input string tag, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = (expq.size() > 0) ? expq.pop_front() : 8'h00;
      chk({tag, "_vld"}, 32'(Byte_Valid), 32'd1);
      chk({tag, "_byte"}, 32'(Byte_Out), 32'(e));
      tick();
    end
  endtask

  task automatic pulse(input logic [31:0] res, input logic c);
    Res_In = res; Carry_In = c; Res_Valid = 1'b1;
    tick();
    Res_Valid = 1'b0;
  endtask

  logic [7:0] hand28 [5] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
  logic [7:0] hand33 [5] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h01};

  initial begin
    // reset state
    tick(); tick();
    chk("rst_byte", 32'(Byte_Out), 32'd0);
    chk("rst_vld", 32'(Byte_Valid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ovr", 32'(Overrun), 32'd0);
    RST = 1'b0;
    tick();

    // single result, latency 2 edges, LSB first
    Byte_Ready = 1'b1;
    pulse(32'h12345678, 1'b0);
    chk("lat_vld_low", 32'(Byte_Valid), 32'd0);
    chk("lat_busy", 32'(Busy), 32'd1);
    tick();
    for (int i = 0; i < FB; i++) begin
      chk("single_vld", 32'(Byte_Valid), 32'd1);
      chk("single_byte", 32'(Byte_Out), 32'(hand28[i]));
      tick();
    end
    chk("single_end_vld", 32'(Byte_Valid), 32'd0);
    chk("single_end_busy", 32'(Busy), 32'd0);

    // backpressure holds the first byte
    Byte_Ready = 1'b0;
    pulse(32'h12345678, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", 32'(Byte_Valid), 32'd1);
      chk("hold_byte", 32'(Byte_Out), 32'h78);
      tick();
    end
    Byte_Ready = 1'b1;
    add_frame(32'h12345678, 1'b0, 1'b0);
    drain_check("bp", FB);
    chk("bp_end_vld", 32'(Byte_Valid), 32'd0);

    // burst of 4 with backpressure: 3 kept, 4th dropped
    Byte_Ready = 1'b0;
    Res_Valid = 1'b1;
    Res_In = 32'h11223344; Carry_In = 1'b1; tick();
    Res_In = 32'h55667788; Carry_In = 1'b0; tick();
    Res_In = 32'h99AABBCC; Carry_In = 1'b1; tick();
    Res_In = 32'hDDEEFF00; Carry_In = 1'b0; tick();
    Res_Valid = 1'b0;
    chk("burst_ovr", 32'(Overrun), 32'd1);
    chk("burst_busy", 32'(Busy), 32'd1);
    add_frame(32'h11223344, 1'b1, 1'b0);
    add_frame(32'h55667788, 1'b0, 1'b0);
    add_frame(32'h99AABBCC, 1'b1, 1'b0);
    Byte_Ready = 1'b1;
    drain_check("burst", 3 * FB);
    chk("burst_end_vld", 32'(Byte_Valid), 32'd0);
    chk("burst_end_busy", 32'(Busy), 32'd0);
    chk("burst_ovr_sticky", 32'(Overrun), 32'd1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("ovr_cleared", 32'(Overrun), 32'd0);

    // push/pop collision on a full FIFO
    Byte_Ready = 1'b0;
    Res_Valid = 1'b1;
    Res_In = 32'hA0A1A2A3; Carry_In = 1'b0; tick();
    Res_In = 32'hB0B1B2B3; Carry_In = 1'b1; tick();
    Res_In = 32'hC0C1C2C3; Carry_In = 1'b0; tick();
    Res_Valid = 1'b0;
    add_frame(32'hA0A1A2A3, 1'b0, 1'b0);
    add_frame(32'hB0B1B2B3, 1'b1, 1'b0);
    add_frame(32'hC0C1C2C3, 1'b0, 1'b0);
    Byte_Ready = 1'b1;
    drain_check("coll_a", FB - 1);
    Res_In = 32'hD0D1D2D3; Carry_In = 1'b1; Res_Valid = 1'b1;
    drain_check("coll_last", 1);
    Res_Valid = 1'b0;
    add_frame(32'hD0D1D2D3, 1'b1, 1'b0);
    chk("coll_ovr", 32'(Overrun), 32'd0);
    drain_check("coll_rest", 3 * FB);
    chk("coll_end_vld", 32'(Byte_Valid), 32'd0);

    // reset mid-frame, Res_Valid on the reset edge is ignored
    pulse(32'hCAFEBABE, 1'b0);
    tick(); tick(); tick();
    RST = 1'b1; Res_Valid = 1'b1; Res_In = 32'h0BADF00D;
    tick();
    RST = 1'b0; Res_Valid = 1'b0;
    chk("mid_rst_byte", 32'(Byte_Out), 32'd0);
    chk("mid_rst_vld", 32'(Byte_Valid), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_ovr", 32'(Overrun), 32'd0);
    tick();
    chk("mid_rst_idle", 32'(Busy), 32'd0);
    expq.delete();
    pulse(32'h0F1E2D3C, 1'b1);
    tick();
    add_frame(32'h0F1E2D3C, 1'b1, 1'b0);
    drain_check("fresh", FB);
    chk("fresh_end_vld", 32'(Byte_Valid), 32'd0);

    // signed value with carry
    pulse(32'hFFFF0001, 1'b1);
    tick();
    for (int i = 0; i < FB; i++) begin
      chk("carry_vld", 32'(Byte_Valid), 32'd1);
      chk("carry_byte", 32'(Byte_Out), 32'(hand33[i]));
      tick();
    end
    chk("carry_end_vld", 32'(Byte_Valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
